seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 173 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver
//   Time-multiplexed driver for a 3-digit common-anode 7-segment display.
//   The digits show operand A (AN0), operand B (AN1) and the CPU result
//   (AN2). A decimal point on the result digit marks a "fresh" result for
//   FRESH_SCANS full scans after each load.
//
// Parameters
//   SCAN_DIV    : clock cycles each digit stays lit (2..2^20)
//   FRESH_SCANS : full scans the fresh-result dp stays lit (1..255)
//
// Ports
//   clock               : system clock, rising edge
//   reset               : synchronous, active-high
//   load                : capture strobe for opa/opb/rezult
//   opa, opb, rezult    : 4-bit values shown on AN0, AN1, AN2
//   blank               : forces all anodes off; scanning keeps running
//   AN0, AN1, AN2       : active-low digit anodes (registered)
//   a, b, c, d, e, fp, g: active-low segments, fp is segment f (registered)
//   dp                  : active-low decimal point (registered)
module seg_scan_driver #(
  parameter int SCAN_DIV    = 50000,
  parameter int FRESH_SCANS = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] opa,
  input  logic [3:0] opb,
  input  logic [3:0] rezult,
  input  logic       blank,
  output logic       AN0,
  output logic       AN1,
  output logic       AN2,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       fp,
  output logic       g,
  output logic       dp
);

  localparam logic [19:0] PRESC_LAST  = 20'(SCAN_DIV - 1);
  localparam logic [7:0]  FRESH_LIMIT = 8'(FRESH_SCANS);

  typedef enum logic [1:0] {
    DIG0,
    DIG1,
    DIG2
  } state_t;

  // Hex digit to active-low {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  logic [19:0] r_presc;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_a;
  logic [3:0]  r_b;
  logic [3:0]  r_r;
  logic        r_fresh;
  logic [7:0]  r_scan_cnt;
  logic [7:0]  w_cnt_inc;
  logic        w_tick;
  logic        w_wrap;
  logic [3:0]  w_sel;
  logic [2:0]  w_an;
  logic [2:0]  r_an_p1;
  logic [6:0]  r_seg_p1;
  logic        r_dp_p1;

  assign w_tick    = (r_presc == PRESC_LAST);
  assign w_wrap    = w_tick && (r_state == DIG2);
  assign w_cnt_inc = r_scan_cnt + 8'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= DIG0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel       = r_a;
    w_an        = 3'b110;
    case (r_state)
      DIG0: begin
        if (w_tick) w_state_nxt = DIG1;
        w_sel = r_a;
        w_an  = 3'b110;
      end
      DIG1: begin
        if (w_tick) w_state_nxt = DIG2;
        w_sel = r_b;
        w_an  = 3'b101;
      end
      default: begin
        if (w_tick) w_state_nxt = DIG0;
        w_sel = r_r;
        w_an  = 3'b011;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc    <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_r        <= '0;
      r_fresh    <= 1'b0;
      r_scan_cnt <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 20'd1;
      if (load) begin
        r_a <= opa;
        r_b <= opb;
        r_r <= rezult;
      end
      // A load restarts the fresh window even on the same edge the scan
      // wraps, so the counter never sees a stale increment.
      if (load) begin
        r_fresh    <= 1'b1;
        r_scan_cnt <= '0;
      end else if (r_fresh && w_wrap) begin
        r_scan_cnt <= w_cnt_inc;
        if (w_cnt_inc == FRESH_LIMIT) r_fresh <= 1'b0;
      end
    end
  end

  // Output stage: one-cycle registered view of state, registers and blank
  always_ff @(posedge clock) begin
    if (reset) begin
      r_an_p1  <= 3'b111;
      r_seg_p1 <= 7'b1111111;
      r_dp_p1  <= 1'b1;
    end else begin
      r_an_p1  <= blank ? 3'b111 : w_an;
      r_seg_p1 <= seg_decode(w_sel);
      r_dp_p1  <= ~((r_state == DIG2) && r_fresh && !blank);
    end
  end

  assign {AN2, AN1, AN0}         = r_an_p1;
  assign {a, b, c, d, e, fp, g}  = r_seg_p1;
  assign dp                      = r_dp_p1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Testbench for seg_scan_driver with SCAN_DIV=4, FRESH_SCANS=2.
// Per-cycle vector table for start-up and the first load, then directed
// sequences for load across a scan wrap, blanking and mid-scan reset.
module tb_seg_scan_driver;

  logic       clock;
  logic       reset;
  logic       load;
  logic [3:0] opa;
  logic [3:0] opb;
  logic [3:0] rezult;
  logic       blank;
  logic       AN0, AN1, AN2;
  logic       a, b, c, d, e, fp, g;
  logic       dp;

  seg_scan_driver #(
    .SCAN_DIV   (4),
    .FRESH_SCANS(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .opa   (opa),
    .opb   (opb),
    .rezult(rezult),
    .blank (blank),
    .AN0   (AN0),
    .AN1   (AN1),
    .AN2   (AN2),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .fp    (fp),
    .g     (g),
    .dp    (dp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Active-low {a,b,c,d,e,f,g}
  localparam logic [6:0] SOFF = 7'b1111111;
  localparam logic [6:0] S0   = 7'b0000001;
  localparam logic [6:0] S2   = 7'b0010010;
  localparam logic [6:0] S6   = 7'b0100000;
  localparam logic [6:0] S9   = 7'b0000100;
  localparam logic [6:0] SA   = 7'b0001000;
  localparam logic [6:0] SD   = 7'b1000010;
  localparam logic [6:0] SF   = 7'b0111000;
  // {AN2,AN1,AN0}
  localparam logic [2:0] A0   = 3'b110;
  localparam logic [2:0] A1   = 3'b101;
  localparam logic [2:0] A2   = 3'b011;
  localparam logic [2:0] AOFF = 3'b111;

  typedef struct {
    logic       rst;
    logic       ld;
    logic       blk;
    logic [3:0] va;
    logic [3:0] vb;
    logic [3:0] vr;
    logic [2:0] an;
    logic [6:0] seg;
    logic       dpx;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp;
  int   n_err;

  task automatic add(input logic rst, input logic ld, input logic blk,
                     input logic [3:0] va, input logic [3:0] vb,
                     input logic [3:0] vr, input logic [2:0] an,
                     input logic [6:0] seg, input logic dpx, input int n);
    vec_t v;
    v.rst = rst; v.ld = ld; v.blk = blk;
    v.va = va; v.vb = vb; v.vr = vr;
    v.an = an; v.seg = seg; v.dpx = dpx;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] an,
                     input logic [6:0] seg, input logic dpx,
                     input bit chk_seg);
    logic [2:0] got_an;
    logic [6:0] got_seg;
    got_an  = {AN2, AN1, AN0};
    got_seg = {a, b, c, d, e, fp, g};
    n_cmp++;
    if (got_an !== an || dp !== dpx || (chk_seg && got_seg !== seg)) begin
      n_err++;
      $display("FAIL %s t=%0t: got AN=%b seg=%b dp=%b, want AN=%b seg=%b dp=%b",
               name, $time, got_an, got_seg, dp, an,
               chk_seg ? seg : got_seg, dpx);
    end
  endtask

  // Step n cycles with the current inputs, checking each cycle.
  task automatic run(input string name, input int n, input logic [2:0] an,
                     input logic [6:0] seg, input logic dpx);
    for (int i = 0; i < n; i++) begin
      step();
      chk(name, an, seg, dpx, 1'b1);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b1;
    load   = 1'b0;
    blank  = 1'b0;
    opa    = 4'h0;
    opb    = 4'h0;
    rezult = 4'h0;

    // Reset, start-up scan, then load F/6/9 and watch two fresh scans expire
    add(1, 0, 0, 4'h0, 4'h0, 4'h0, AOFF, SOFF, 1, 2);
    add(0, 0, 0, 4'h0, 4'h0, 4'h0, A0,   S0,   1, 4);
    add(0, 0, 0, 4'h0, 4'h0, 4'h0, A1,   S0,   1, 4);
    add(0, 0, 0, 4'h0, 4'h0, 4'h0, A2,   S0,   1, 4);
    add(0, 0, 0, 4'h0, 4'h0, 4'h0, A0,   S0,   1, 1);
    add(0, 1, 0, 4'hF, 4'h6, 4'h9, A0,   S0,   1, 1);
    add(0, 0, 0, 4'hF, 4'h6, 4'h9, A0,   SF,   1, 2);
    add(0, 0, 0, 4'hF, 4'h6, 4'h9, A1,   S6,   1, 4);
    add(0, 0, 0, 4'hF, 4'h6, 4'h9, A2,   S9,   0, 4);
    add(0, 0, 0, 4'hF, 4'h6, 4'h9, A0,   SF,   1, 4);
    add(0, 0, 0, 4'hF, 4'h6, 4'h9, A1,   S6,   1, 4);
    add(0, 0, 0, 4'hF, 4'h6, 4'h9, A2,   S9,   0, 4);
    add(0, 0, 0, 4'hF, 4'h6, 4'h9, A0,   SF,   1, 4);
    add(0, 0, 0, 4'hF, 4'h6, 4'h9, A1,   S6,   1, 4);
    add(0, 0, 0, 4'hF, 4'h6, 4'h9, A2,   S9,   1, 4);

    for (int i = 0; i < tbl.size(); i++) begin
      reset  = tbl[i].rst;
      load   = tbl[i].ld;
      blank  = tbl[i].blk;
      opa    = tbl[i].va;
      opb    = tbl[i].vb;
      rezult = tbl[i].vr;
      step();
      chk($sformatf("vec%0d", i), tbl[i].an, tbl[i].seg, tbl[i].dpx, 1'b1);
    end

    // Load (same values) held across the DIG2->DIG0 wrap
    run("ldwrap_pre0", 4, A0, SF, 1);
    run("ldwrap_pre1", 4, A1, S6, 1);
    run("ldwrap_pre2", 1, A2, S9, 1);
    load = 1'b1;
    run("ldwrap_first", 1, A2, S9, 1);
    run("ldwrap_held2", 2, A2, S9, 0);
    run("ldwrap_held0", 1, A0, SF, 1);
    load = 1'b0;
    run("ldwrap_s1d0", 3, A0, SF, 1);
    run("ldwrap_s1d1", 4, A1, S6, 1);
    run("ldwrap_s1d2", 4, A2, S9, 0);
    run("ldwrap_s2d0", 4, A0, SF, 1);
    run("ldwrap_s2d1", 4, A1, S6, 1);
    run("ldwrap_s2d2", 4, A2, S9, 0);
    run("ldwrap_s3d0", 4, A0, SF, 1);
    run("ldwrap_s3d1", 4, A1, S6, 1);
    run("ldwrap_s3d2", 4, A2, S9, 1);

    // Blank for 6 cycles across a scan wrap; scanning must keep its phase
    opa = 4'h2; opb = 4'hA; rezult = 4'hD;
    load = 1'b1;
    run("blk_load", 1, A0, SF, 1);
    load = 1'b0;
    run("blk_d0", 3, A0, S2, 1);
    run("blk_d1", 4, A1, SA, 1);
    run("blk_d2", 1, A2, SD, 0);
    blank = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("blk_dark", AOFF, SOFF, 1'b1, 1'b0);
    end
    blank = 1'b0;
    run("blk_rel0", 1, A0, S2, 1);
    run("blk_rel1", 4, A1, SA, 1);
    run("blk_rel2", 4, A2, SD, 0);
    run("blk_n0", 4, A0, S2, 1);
    run("blk_n1", 4, A1, SA, 1);
    run("blk_n2", 4, A2, SD, 1);

    // Reset for one cycle while AN2 is lit with fresh dp; load is ignored
    load = 1'b1;
    run("rst_load", 1, A0, S2, 1);
    load = 1'b0;
    run("rst_pre0", 3, A0, S2, 1);
    run("rst_pre1", 4, A1, SA, 1);
    run("rst_pre2", 1, A2, SD, 0);
    reset = 1'b1; load = 1'b1;
    opa = 4'h7; opb = 4'h7; rezult = 4'h7;
    run("rst_edge", 1, AOFF, SOFF, 1);
    reset = 1'b0; load = 1'b0;
    run("rst_rel0", 4, A0, S0, 1);
    run("rst_rel1", 4, A1, S0, 1);
    run("rst_rel2", 4, A2, S0, 1);
    run("rst_rel3", 1, A0, S0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
